// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Signed or unsigned per request, busy/done handshake, defined divide-by-zero
// results. Optional macro DIV_OVF_CHK_EN short-paths signed MIN / -1 and
// raises overflow; without it overflow is tied to 0.
module div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;    // restored partial remainder, always < |divisor|
  logic [WIDTH-1:0] quo_q;    // quotient magnitude, shifted in LSB first
  logic [WIDTH-1:0] dvd_q;    // |dividend|, shifted out MSB first
  logic [WIDTH-1:0] dvs_q;    // |divisor|
  logic             neg_q;    // quotient must be negated
  logic             neg_r;    // remainder takes a negative sign
  logic             dbz_q;

  // operand sign and magnitude decode at accept time
  logic             dvd_neg, dvs_neg, short_path;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  // one restoring step; the shifted value needs WIDTH+1 bits
  logic [WIDTH:0]   rem_shift, trial;
  logic             q_bit;
  // control strobes and final signed results
  logic             accept, step, finish;
  logic [WIDTH-1:0] res_q, res_r;

`ifdef DIV_OVF_CHK_EN
  logic ovf_case, ovf_q;
  assign ovf_case = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
`endif

  // operand decode and single restoring iteration
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dvd_neg    = signed_mode & dividend[WIDTH-1];
    dvs_neg    = signed_mode & divisor[WIDTH-1];
    dvd_mag    = dvd_neg ? -dividend : dividend;
    dvs_mag    = dvs_neg ? -divisor  : divisor;
    short_path = (divisor == '0);
`ifdef DIV_OVF_CHK_EN
    short_path = short_path | ovf_case;
`endif
    rem_shift  = {rem_q, dvd_q[WIDTH-1]};
    trial      = rem_shift - {1'b0, dvs_q};
    q_bit      = ~trial[WIDTH];
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = short_path ? FINISH : CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control strobes decoded from the current state
  always_comb begin
    accept = (state == IDLE) && start;
    step   = (state == CALC);
    finish = (state == FINISH);
  end

  // final sign correction and special-case results
  always_comb begin
    res_q = neg_q ? -quo_q : quo_q;
    res_r = neg_r ? -rem_q : rem_q;
    if (dbz_q) begin
      res_q = '1;
      res_r = neg_r ? -dvd_q : dvd_q;   // restores the original dividend bits
    end
`ifdef DIV_OVF_CHK_EN
    if (ovf_q) begin
      res_q = {1'b1, {(WIDTH-1){1'b0}}};
      res_r = '0;
    end
`endif
  end

  // datapath: latch operands on accept, iterate while in CALC
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all datapath registers are plain flops (no memory array), so each is reset to 0.
    if (!reset) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvd_q <= dvd_mag;
      dvs_q <= dvs_mag;
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
      dbz_q <= (divisor == '0);
    end else if (step) begin
      cnt   <= cnt + 1'b1;
      rem_q <= q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
      dvd_q <= dvd_q << 1;
    end
  end

`ifdef DIV_OVF_CHK_EN
  // overflow flag captured with the operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ovf_q <= 1'b0;
    else if (accept) ovf_q <= ovf_case;
  end
`endif

  // registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (finish) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= dbz_q;
      end
    end
  end

`ifdef DIV_OVF_CHK_EN
  // overflow result register, updated with done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      overflow <= 1'b0;
    else if (finish) overflow <= ovf_q;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (WIDTH=16).
// Directed table, randomized operations against an arithmetic model,
// continuous-start streaming, and a mid-operation reset.
module tb_div_seq;

  localparam int W = 16;
`ifdef DIV_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic         clk, reset, start, signed_mode;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         done, busy, div_by_zero, overflow;

  div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .done(done), .busy(busy), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  bit           both_seen = 1'b0;

  always @(negedge clk) if (busy && done) both_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain integer division, with the special cases stated directly
  task automatic model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output logic ovf, output int lat);
    longint sa, sb;
    dbz = (b == '0);
    ovf = 1'b0;
    if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else if (OVF_EN && m && a == MIN && b == '1) begin
      q = MIN; r = '0; ovf = 1'b1; lat = 1;
    end else begin
      if (m) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else   begin sa = longint'(a);          sb = longint'(b);          end
      q = W'(sa / sb);
      r = W'(sa % sb);
      lat = W + 1;
    end
  endtask

  task automatic do_op(input string name, input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz, input logic eovf, input int elat);
    int cyc;
    bit got;
    @(negedge clk);
    start = 1'b1; signed_mode = m; dividend = a; divisor = b;
    @(posedge clk); #1;
    // scramble inputs: they must not influence the accepted operation
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom); signed_mode = 1'($urandom);
    check({name, ":busy_after_accept"}, busy, 1);
    check({name, ":q_held_on_start"}, quotient, prev_q);
    check({name, ":r_held_on_start"}, remainder, prev_r);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check({name, ":done_seen"}, got, 1);
    check({name, ":latency"}, cyc, elat);
    check({name, ":quotient"}, quotient, eq);
    check({name, ":remainder"}, remainder, er);
    check({name, ":div_by_zero"}, div_by_zero, edbz);
    check({name, ":overflow"}, overflow, eovf);
    check({name, ":busy_at_done"}, busy, 0);
    prev_q = eq; prev_r = er;
    @(posedge clk); #1;
    check({name, ":done_one_cycle"}, done, 0);
    check({name, ":q_holds"}, quotient, eq);
  endtask

  typedef struct {
    logic         m;
    logic [W-1:0] a, b, q, r;
    logic         dbz, ovf;
    int           lat;
    string        name;
  } vec_t;

  typedef struct {
    logic         m;
    logic [W-1:0] a, b;
  } op_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] eq, er, a, b;
    logic         edbz, eovf, m;
    int           elat, last_acc, c;
    bit           done_after_reset;
    op_t          pend[$];
    op_t          op;

    vecs[0] = '{1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0,   17, "s_100_7"};
    vecs[1] = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0,   17, "s_m100_7"};
    vecs[2] = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0,   17, "s_100_m7"};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 1'b0, 1'b0,   17, "u_ffff_2"};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF, 1'b0, 1'b0,   17, "s_m1_2"};
    vecs[5] = '{1'b1, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0,   1,  "s_dbz"};
    vecs[6] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, OVF_EN, OVF_EN ? 1 : 17, "s_min_m1"};
    vecs[7] = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0,   1,  "u_dbz"};
    vecs[8] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0,   17, "u_8000_ffff"};
    vecs[9] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0,   17, "u_ffff_ffff"};

    // reset state
    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst:quotient", quotient, 0);
    check("rst:remainder", remainder, 0);
    check("rst:done", done, 0);
    check("rst:busy", busy, 0);
    check("rst:div_by_zero", div_by_zero, 0);
    check("rst:overflow", overflow, 0);
    @(negedge clk); reset = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].name, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].dbz, vecs[i].ovf, vecs[i].lat);

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = MIN;
        1:       a = '1;
        2:       a = '0;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2, 3:    b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      model(m, a, b, eq, er, edbz, eovf, elat);
      do_op("rand", m, a, b, eq, er, edbz, eovf, elat);
    end

    // start held high with new operands every cycle
    last_acc = -1;
    for (c = 0; c < 4 * (W + 2) + 2; c++) begin
      @(negedge clk);
      if (done) begin
        if (pend.size() == 0) check("stream:unexpected_done", 1, 0);
        else begin
          op = pend.pop_front();
          model(op.m, op.a, op.b, eq, er, edbz, eovf, elat);
          check("stream:quotient", quotient, eq);
          check("stream:remainder", remainder, er);
          prev_q = eq; prev_r = er;
        end
      end
      op.m = 1'($urandom);
      op.a = W'($urandom);
      op.b = W'($urandom_range(1, (1 << W) - 1));
      if (op.m && op.a == MIN && op.b == '1) op.b = W'(1);
      if (!busy) begin
        pend.push_back(op);
        if (last_acc >= 0) check("stream:accept_interval", c - last_acc, W + 2);
        last_acc = c;
      end
      start = 1'b1; signed_mode = op.m; dividend = op.a; divisor = op.b;
    end
    // drain the outstanding operation
    start = 1'b0;
    for (int k = 0; k < W + 4 && pend.size() != 0; k++) begin
      @(negedge clk);
      if (done) begin
        op = pend.pop_front();
        model(op.m, op.a, op.b, eq, er, edbz, eovf, elat);
        check("stream:drain_quotient", quotient, eq);
        check("stream:drain_remainder", remainder, er);
        prev_q = eq; prev_r = er;
      end
    end
    check("stream:all_drained", pend.size(), 0);

    // mid-operation reset
    do_op("pre_rst", 1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst:quotient", quotient, 0);
    check("midrst:remainder", remainder, 0);
    check("midrst:busy", busy, 0);
    check("midrst:done", done, 0);
    check("midrst:div_by_zero", div_by_zero, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    prev_q = '0; prev_r = '0;
    done_after_reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) done_after_reset = 1'b1;
    end
    check("midrst:no_done", done_after_reset, 0);
    do_op("post_rst_9_3", 1'b1, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 17);

    check("busy_and_done_never_both", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
